tile_streamer: RTL and testbench

- Source side of the edge-detection CHIP pixel interface.
- Reads a frame from a 5-row-wide frame-buffer read port and cuts it into overlapping 20x20 tiles (stride 18). Streams each tile to CHIP on five 5-bit lanes over 80 cycles.
- Pulses the CHIP per-tile reset and raises load_end. Holds off the next tile until CHIP has delivered all 324 (18x18) readable edge bits.

---
 rtl/tile_stream_pkg.sv | 14 +
 rtl/tile_addr_gen.sv | 21 ++
 rtl/tile_streamer.sv | 170 +++++++++++++++++
 tb/tb_tile_streamer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/tile_stream_pkg.sv
// tile_stream_pkg: shared state encoding, tile geometry constants and tile-count helpers
package tile_stream_pkg;
    typedef enum logic [2:0] {IDLE = 3'd0, CRST = 3'd1, LOAD = 3'd2, DRAIN = 3'd3, NEXT = 3'd4} state_t;
    localparam int TILE_IN  = 20;
    localparam int TILE_OUT = 18;
    localparam int LANES    = 5;
    localparam int LOAD_CYC = 80;
    function automatic int ntx(input int img_w);
        return (img_w - 2) / TILE_OUT;
    endfunction
    function automatic int nty(input int img_h);
        return (img_h - 2) / TILE_OUT;
    endfunction
endpackage

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: maps (tile index, load cycle) to the frame-buffer row/column of lane 0
module tile_addr_gen import tile_stream_pkg::*; #(
    parameter int IMG_W = 74
) (
    input  logic [3:0] tile_idx,
    input  logic [6:0] c,
    output logic [6:0] mem_row,
    output logic [6:0] mem_col
);
    localparam int NTX = ntx(IMG_W);
    logic [7:0] tx, ty, b, x;
    always_comb begin
        tx = 8'(tile_idx % 4'(NTX));
        ty = 8'(tile_idx / 4'(NTX));
        b  = 8'(c / 7'(TILE_IN));
        x  = 8'(c % 7'(TILE_IN));
    end
    // addresses are formed in 8 bits; the top-level parameter check keeps them below 128
    assign mem_row = 7'(8'(TILE_OUT) * ty + 8'(LANES) * b);
    assign mem_col = 7'(8'(TILE_OUT) * tx + x);
endmodule

// File: rtl/tile_streamer.sv
// tile_streamer: cuts a frame into overlapping 20x20 tiles and streams them to CHIP on five lanes.
// Define DRAIN_TIMEOUT_EN to add a drain watchdog and the timeout_err output.
module tile_streamer import tile_stream_pkg::*; #(
    parameter int IMG_W        = 74,
    parameter int IMG_H        = 56,
    parameter int PIX_W        = 5,
    parameter int OUT_PER_TILE = 324
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   mem_rd,
    output logic [6:0]             mem_row,
    output logic [6:0]             mem_col,
    input  logic [LANES*PIX_W-1:0] mem_rdata,
    output logic                   chip_rst,
    output logic [PIX_W-1:0]       pixel_in0,
    output logic [PIX_W-1:0]       pixel_in1,
    output logic [PIX_W-1:0]       pixel_in2,
    output logic [PIX_W-1:0]       pixel_in3,
    output logic [PIX_W-1:0]       pixel_in4,
    output logic                   load_end,
    input  logic                   readable,
    output logic [3:0]             tile_idx,
    output logic                   busy,
    output logic                   done
`ifdef DRAIN_TIMEOUT_EN
    ,
    output logic                   timeout_err
`endif
);
    localparam int NT = ntx(IMG_W) * nty(IMG_H);
    localparam logic [3:0] LAST_TILE = 4'(NT - 1);

    if ((IMG_W - 2) % TILE_OUT != 0 || (IMG_H - 2) % TILE_OUT != 0 || IMG_W > 128 || IMG_H > 128 || NT < 1 || NT > 16)
        begin : g_bad_params
            $error("tile_streamer: unsupported IMG_W/IMG_H");
        end

    state_t                   state_q, state_d;
    logic [6:0]               c_q, c_d;
    logic [8:0]               drain_q, drain_d;
    logic [3:0]               tile_q, tile_d;
    logic [LANES*PIX_W-1:0]   pix_q, pix_d;
    logic                     load_end_q, load_end_d;
    logic                     done_q, done_d;
    logic [6:0]               row_raw, col_raw;
`ifdef DRAIN_TIMEOUT_EN
    logic [10:0]              wd_q, wd_d;
    logic                     terr_q, terr_d;
`endif

    tile_addr_gen #(.IMG_W(IMG_W)) u_addr (
        .tile_idx (tile_q),
        .c        (c_q),
        .mem_row  (row_raw),
        .mem_col  (col_raw)
    );

    assign mem_rd   = state_q == LOAD && c_q < 7'(LOAD_CYC);
    assign mem_row  = mem_rd ? row_raw : 7'd0;
    assign mem_col  = mem_rd ? col_raw : 7'd0;
    assign chip_rst = state_q == CRST;
    assign busy     = state_q != IDLE;
    assign done     = done_q;
    assign load_end = load_end_q;
    assign tile_idx = tile_q;
    assign pixel_in0 = pix_q[0*PIX_W +: PIX_W];
    assign pixel_in1 = pix_q[1*PIX_W +: PIX_W];
    assign pixel_in2 = pix_q[2*PIX_W +: PIX_W];
    assign pixel_in3 = pix_q[3*PIX_W +: PIX_W];
    assign pixel_in4 = pix_q[4*PIX_W +: PIX_W];
`ifdef DRAIN_TIMEOUT_EN
    assign timeout_err = terr_q;
`endif

    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        drain_d    = drain_q;
        tile_d     = tile_q;
        pix_d      = mem_rd ? mem_rdata : pix_q;
        load_end_d = load_end_q;
        done_d     = 1'b0;
`ifdef DRAIN_TIMEOUT_EN
        wd_d       = wd_q;
        terr_d     = terr_q;
`endif
        case (state_q)
            IDLE: begin
                // a start arriving with the done pulse belongs to the finished frame
                if (start && !done_q) begin
                    state_d = CRST;
                    tile_d  = 4'd0;
`ifdef DRAIN_TIMEOUT_EN
                    terr_d  = 1'b0;
`endif
                end
            end
            CRST: begin
                c_d     = 7'd0;
                drain_d = 9'd0;
`ifdef DRAIN_TIMEOUT_EN
                wd_d    = 11'd0;
`endif
                state_d = LOAD;
            end
            LOAD: begin
                c_d = c_q + 7'd1;
                if (c_q == 7'(LOAD_CYC - 1)) load_end_d = 1'b1;
                if (c_q == 7'(LOAD_CYC)) state_d = DRAIN;
            end
            DRAIN: begin
                if (readable) begin
                    drain_d = drain_q + 9'd1;
                    if (drain_q == 9'(OUT_PER_TILE - 1)) begin
                        load_end_d = 1'b0;
                        state_d    = NEXT;
                    end
                end
`ifdef DRAIN_TIMEOUT_EN
                wd_d = readable ? 11'd0 : wd_q + 11'd1;
                if (!readable && wd_q == 11'd1023) begin
                    terr_d     = 1'b1;
                    load_end_d = 1'b0;
                    state_d    = NEXT;
                end
`endif
            end
            NEXT: begin
                if (tile_q == LAST_TILE) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tile_d  = tile_q + 4'd1;
                    state_d = CRST;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            c_q        <= '0;
            drain_q    <= '0;
            tile_q     <= '0;
            pix_q      <= '0;
            load_end_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef DRAIN_TIMEOUT_EN
            wd_q       <= '0;
            terr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            drain_q    <= drain_d;
            tile_q     <= tile_d;
            pix_q      <= pix_d;
            load_end_q <= load_end_d;
            done_q     <= done_d;
`ifdef DRAIN_TIMEOUT_EN
            wd_q       <= wd_d;
            terr_q     <= terr_d;
`endif
        end
    end
endmodule

// File: tb/tb_tile_streamer.sv
// tb_tile_streamer: directed bench for tile_streamer with a pixel(r,c)=(r+c)%32 frame buffer.
// Covers the DRAIN_TIMEOUT_EN watchdog when that macro is defined.
module tb_tile_streamer;
    logic        clk = 1'b0;
    logic        reset, start, readable;
    logic        mem_rd, chip_rst, load_end, busy, done;
    logic [6:0]  mem_row, mem_col;
    logic [24:0] mem_rdata;
    logic [4:0]  pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4;
    logic [3:0]  tile_idx;
`ifdef DRAIN_TIMEOUT_EN
    logic        timeout_err;
`endif
    int vectors = 0;
    int miscompares = 0;
    int rd_cnt = 0;
    int rd_base, n;

    always #5 clk = ~clk;

    tile_streamer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_rd    (mem_rd),
        .mem_row   (mem_row),
        .mem_col   (mem_col),
        .mem_rdata (mem_rdata),
        .chip_rst  (chip_rst),
        .pixel_in0 (pixel_in0),
        .pixel_in1 (pixel_in1),
        .pixel_in2 (pixel_in2),
        .pixel_in3 (pixel_in3),
        .pixel_in4 (pixel_in4),
        .load_end  (load_end),
        .readable  (readable),
        .tile_idx  (tile_idx),
        .busy      (busy),
        .done      (done)
`ifdef DRAIN_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always_comb begin
        mem_rdata = '0;
        for (int k = 0; k < 5; k++)
            mem_rdata[k*5 +: 5] = 5'((int'(mem_row) + k + int'(mem_col)) % 32);
    end

    always @(posedge clk) if (mem_rd) rd_cnt <= rd_cnt + 1;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // entered in the CRST cycle of tile t, returns in its NEXT cycle; readable is held by the caller
    task automatic run_tile(input int t);
        int r0, c0, cnt;
        r0 = 18 * (t / 4);
        c0 = 18 * (t % 4);
        check("tile_idx", tile_idx, t);
        check("crst", chip_rst, 1);
        tick;
        check("row0", mem_row, r0);
        check("col0", mem_col, c0);
        tick;
        check("lane0_first", pixel_in0, (r0 + c0) % 32);
        check("lane4_first", pixel_in4, (r0 + 4 + c0) % 32);
        cnt = 0;
        while (!load_end && cnt < 100) begin tick; cnt++; end
        check("load_len", cnt, 79);
        tick;
        cnt = 0;
        while (load_end && cnt < 2000) begin tick; cnt++; end
        check("drain_len", cnt, 324);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; readable = 1'b0;
        repeat (3) tick;
        check("rst_busy", busy, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_chip_rst", chip_rst, 0);
        check("rst_load_end", load_end, 0);
        check("rst_tile_idx", tile_idx, 0);
        check("rst_pixel0", pixel_in0, 0);
        check("rst_done", done, 0);
        reset = 1'b1;
        tick;
        rd_base = rd_cnt;
        // tile 0 by hand
        start = 1'b1;
        tick;
        start = 1'b0;
        check("t0_crst", chip_rst, 1);
        check("t0_busy", busy, 1);
        tick;
        check("t0_crst_len", chip_rst, 0);
        check("t0_rd0", mem_rd, 1);
        check("t0_row0", mem_row, 0);
        check("t0_col0", mem_col, 0);
        tick;
        check("t0_c1_l0", pixel_in0, 0);
        check("t0_c1_l1", pixel_in1, 1);
        check("t0_c1_l2", pixel_in2, 2);
        check("t0_c1_l3", pixel_in3, 3);
        check("t0_c1_l4", pixel_in4, 4);
        for (int cc = 1; cc < 80; cc++) begin
            start = (cc == 5);
            if (cc == 79) check("t0_le_early", load_end, 0);
            tick;
        end
        start = 1'b0;
        check("t0_c80_rd", mem_rd, 0);
        check("t0_c80_le", load_end, 1);
        check("t0_c80_l0", pixel_in0, 2);
        check("t0_c80_l1", pixel_in1, 3);
        check("t0_c80_l2", pixel_in2, 4);
        check("t0_c80_l3", pixel_in3, 5);
        check("t0_c80_l4", pixel_in4, 6);
        check("t0_tile", tile_idx, 0);
        tick;
        for (int i = 0; i < 647; i++) begin
            readable = (i % 2 == 0);
            if (i == 646) check("t0_le_before_last", load_end, 1);
            tick;
        end
        readable = 1'b0;
        check("t0_le_drop", load_end, 0);
        check("t0_next_no_rst", chip_rst, 0);
        tick;
        check("t0_next_crst", chip_rst, 1);
        // tiles 1..11, readable held high (ignored outside DRAIN)
        readable = 1'b1;
        for (int t = 1; t < 12; t++) begin
            run_tile(t);
            if (t < 11) tick;
        end
        check("last_next_done", done, 0);
        check("last_next_busy", busy, 1);
        start = 1'b1;
        tick;
        start = 1'b0;
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        tick;
        check("done_once", done, 0);
        check("start_with_done_ignored", busy, 0);
        check("rd_total", rd_cnt - rd_base, 960);
        readable = 1'b0;
        // reset in LOAD at c=40
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        repeat (40) tick;
        check("c40_rd", mem_rd, 1);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        check("mid_rst_rd", mem_rd, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pix0", pixel_in0, 0);
        check("mid_rst_pix4", pixel_in4, 0);
        check("mid_rst_row", mem_row, 0);
        check("mid_rst_col", mem_col, 0);
        check("mid_rst_tile", tile_idx, 0);
        rd_base = rd_cnt;
        repeat (10) tick;
        check("mid_rst_no_reads", rd_cnt - rd_base, 0);
        check("mid_rst_idle", busy, 0);
`ifdef DRAIN_TIMEOUT_EN
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (!load_end && n < 200) begin tick; n++; end
        check("to_loaded", load_end, 1);
        tick;
        n = 0;
        while (!timeout_err && n < 1100) begin tick; n++; end
        check("to_cycles", n, 1024);
        check("to_le", load_end, 0);
        check("to_tile_hold", tile_idx, 0);
        tick;
        check("to_tile_inc", tile_idx, 1);
        check("to_crst", chip_rst, 1);
        check("to_sticky", timeout_err, 1);
        reset = 1'b0;
        tick;
        reset = 1'b1;
        check("to_cleared", timeout_err, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
